pipelined_control_unit: RTL

- Next-generation MIPS control unit. Decodes op/funct in ID, then carries the control bundle through registered ID/EX, EX/MEM and MEM/WB stages.
- Adds bubble insertion, an illegal-instruction flag, an extended opcode set, and a multi-cycle multiply sequencer with its own stall request.
- Sits between the instruction register (IF/ID) and the datapath. The hazard unit consumes o_StallMd and the ID-stage outputs.

---
 rtl/pipelined_control_unit_pkg.sv | 63 ++++++
 rtl/pipelined_control_unit_if.sv | 45 ++++
 rtl/pipelined_control_unit_decoder.sv | 77 +++++++
 rtl/pipelined_control_unit.sv | 137 +++++++++++++
 4 files changed

// File: rtl/pipelined_control_unit_pkg.sv
// Shared encodings and types for the pipelined MIPS control unit.
// Holds opcode/funct/ALU codes, the per-stage control bundles and the multiply sequencer state.
package cu_pkg;

   localparam int CTRL_ALU_W = 3;

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_BNE   = 6'b000101;
   localparam logic [5:0] OP_ADDI  = 6'b001000;
   localparam logic [5:0] OP_ORI   = 6'b001101;
   localparam logic [5:0] OP_SLTI  = 6'b001010;
   localparam logic [5:0] OP_J     = 6'b000010;

   localparam logic [5:0] FUNCT_ADD  = 6'b100000;
   localparam logic [5:0] FUNCT_SUB  = 6'b100010;
   localparam logic [5:0] FUNCT_AND  = 6'b100100;
   localparam logic [5:0] FUNCT_OR   = 6'b100101;
   localparam logic [5:0] FUNCT_NOR  = 6'b100111;
   localparam logic [5:0] FUNCT_SLT  = 6'b101010;
   localparam logic [5:0] FUNCT_MULT = 6'b011000;
   localparam logic [5:0] FUNCT_MFLO = 6'b010010;

   localparam logic [CTRL_ALU_W-1:0] ALU_AND = 3'b000;
   localparam logic [CTRL_ALU_W-1:0] ALU_OR  = 3'b001;
   localparam logic [CTRL_ALU_W-1:0] ALU_ADD = 3'b010;
   localparam logic [CTRL_ALU_W-1:0] ALU_NOR = 3'b100;
   localparam logic [CTRL_ALU_W-1:0] ALU_SUB = 3'b110;
   localparam logic [CTRL_ALU_W-1:0] ALU_SLT = 3'b111;

   typedef struct packed {
      logic                  RegWrite;
      logic                  MemtoReg;
      logic                  MemWrite;
      logic [CTRL_ALU_W-1:0] ALUControl;
      logic                  ALUSrc;
      logic                  RegDst;
      logic                  Mflo;
      logic                  MdStart;
   } ctrl_t;

   // Only the fields still consumed downstream survive past EX.
   typedef struct packed {
      logic RegWrite;
      logic MemtoReg;
      logic MemWrite;
   } memCtrl_t;

   typedef struct packed {
      logic RegWrite;
      logic MemtoReg;
   } wbCtrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

   typedef enum logic {
      MD_IDLE = 1'b0,
      MD_BUSY = 1'b1
   } mdState_t;

endpackage

// File: rtl/pipelined_control_unit_if.sv
// Instruction-side inputs and stage control outputs of the pipelined control unit.
// The control unit binds the slave modport; the instruction/hazard side binds master.
interface pipelined_control_unit_if #(
   parameter int ALUCTRL_W = 3
);
   logic [5:0]           i_Op;
   logic [5:0]           i_funct;
   logic                 i_FlushE;
   logic                 o_RegWriteD;
   logic                 o_BranchD;
   logic                 o_BranchNeD;
   logic                 o_JumpD;
   logic                 o_IllegalD;
   logic [ALUCTRL_W-1:0] o_ALUControlE;
   logic                 o_ALUSrcE;
   logic                 o_RegDstE;
   logic                 o_MfloE;
   logic                 o_MemWriteM;
   logic                 o_MemtoRegM;
   logic                 o_RegWriteM;
   logic                 o_MemtoRegW;
   logic                 o_RegWriteW;
   logic                 o_MdBusy;
   logic                 o_MdDone;
   logic                 o_StallMd;

   modport master (
      output i_Op, i_funct, i_FlushE,
      input  o_RegWriteD, o_BranchD, o_BranchNeD, o_JumpD, o_IllegalD,
      input  o_ALUControlE, o_ALUSrcE, o_RegDstE, o_MfloE,
      input  o_MemWriteM, o_MemtoRegM, o_RegWriteM,
      input  o_MemtoRegW, o_RegWriteW,
      input  o_MdBusy, o_MdDone, o_StallMd
   );

   modport slave (
      input  i_Op, i_funct, i_FlushE,
      output o_RegWriteD, o_BranchD, o_BranchNeD, o_JumpD, o_IllegalD,
      output o_ALUControlE, o_ALUSrcE, o_RegDstE, o_MfloE,
      output o_MemWriteM, o_MemtoRegM, o_RegWriteM,
      output o_MemtoRegW, o_RegWriteW,
      output o_MdBusy, o_MdDone, o_StallMd
   );

endinterface

// File: rtl/pipelined_control_unit_decoder.sv
// Combinational ID-stage decoder: op/funct to control bundle, branch/jump flags and illegal flag.
// mult/mflo are only recognised when CU_MDU_EN is defined; otherwise they decode as illegal.
module cu_decoder
   import cu_pkg::*;
(
   input  logic [5:0] op,
   input  logic [5:0] funct,
   output ctrl_t      ctrl,
   output logic       branch,
   output logic       branchNe,
   output logic       jump,
   output logic       illegal
);

   // Every unknown op or funct leaves the bundle all-zero so it travels as a bubble.
   always_comb begin
      ctrl     = CTRL_BUBBLE;
      branch   = 1'b0;
      branchNe = 1'b0;
      jump     = 1'b0;
      illegal  = 1'b0;
      case (op)
         OP_RTYPE: begin
            case (funct)
               FUNCT_ADD: begin ctrl.RegWrite = 1'b1; ctrl.RegDst = 1'b1; ctrl.ALUControl = ALU_ADD; end
               FUNCT_SUB: begin ctrl.RegWrite = 1'b1; ctrl.RegDst = 1'b1; ctrl.ALUControl = ALU_SUB; end
               FUNCT_AND: begin ctrl.RegWrite = 1'b1; ctrl.RegDst = 1'b1; ctrl.ALUControl = ALU_AND; end
               FUNCT_OR:  begin ctrl.RegWrite = 1'b1; ctrl.RegDst = 1'b1; ctrl.ALUControl = ALU_OR;  end
               FUNCT_NOR: begin ctrl.RegWrite = 1'b1; ctrl.RegDst = 1'b1; ctrl.ALUControl = ALU_NOR; end
               FUNCT_SLT: begin ctrl.RegWrite = 1'b1; ctrl.RegDst = 1'b1; ctrl.ALUControl = ALU_SLT; end
`ifdef CU_MDU_EN
               FUNCT_MULT: ctrl.MdStart = 1'b1;
               FUNCT_MFLO: begin ctrl.RegWrite = 1'b1; ctrl.RegDst = 1'b1; ctrl.Mflo = 1'b1; end
`endif
               default: illegal = 1'b1;
            endcase
         end
         OP_LW: begin
            ctrl.RegWrite   = 1'b1;
            ctrl.ALUSrc     = 1'b1;
            ctrl.MemtoReg   = 1'b1;
            ctrl.ALUControl = ALU_ADD;
         end
         OP_SW: begin
            ctrl.MemWrite   = 1'b1;
            ctrl.ALUSrc     = 1'b1;
            ctrl.ALUControl = ALU_ADD;
         end
         OP_BEQ: begin
            branch          = 1'b1;
            ctrl.ALUControl = ALU_SUB;
         end
         OP_BNE: begin
            branchNe        = 1'b1;
            ctrl.ALUControl = ALU_SUB;
         end
         OP_ADDI: begin
            ctrl.RegWrite   = 1'b1;
            ctrl.ALUSrc     = 1'b1;
            ctrl.ALUControl = ALU_ADD;
         end
         OP_ORI: begin
            ctrl.RegWrite   = 1'b1;
            ctrl.ALUSrc     = 1'b1;
            ctrl.ALUControl = ALU_OR;
         end
         OP_SLTI: begin
            ctrl.RegWrite   = 1'b1;
            ctrl.ALUSrc     = 1'b1;
            ctrl.ALUControl = ALU_SLT;
         end
         OP_J:    jump    = 1'b1;
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/pipelined_control_unit.sv
// Pipelined MIPS control unit: ID decode, ID/EX, EX/MEM and MEM/WB control registers.
// Define CU_MDU_EN to build mult/mflo decoding and the multi-cycle multiply sequencer.
module pipelined_control_unit
   import cu_pkg::*;
#(
   parameter int ALUCTRL_W = 3,
   parameter int MDU_LAT   = 8,
   parameter int CNT_W     = 4
) (
   input logic                    i_clk,
   input logic                    i_rst,
   pipelined_control_unit_if.slave bus
);

   ctrl_t    idCtrl;
   ctrl_t    idEx;
   memCtrl_t exMem;
   wbCtrl_t  memWb;
   logic     branchD;
   logic     branchNeD;
   logic     jumpD;
   logic     illegalD;
   logic     stall;
   logic     bubble;

   cu_decoder decoder (
      .op       (bus.i_Op),
      .funct    (bus.i_funct),
      .ctrl     (idCtrl),
      .branch   (branchD),
      .branchNe (branchNeD),
      .jump     (jumpD),
      .illegal  (illegalD)
   );

   assign bubble = bus.i_FlushE || stall;

   // ID/EX takes a bubble whenever the hazard unit flushes or the multiplier holds ID.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         idEx  <= CTRL_BUBBLE;
         exMem <= '0;
         memWb <= '0;
      end else begin
         idEx  <= bubble ? CTRL_BUBBLE : idCtrl;
         exMem <= '{RegWrite: idEx.RegWrite, MemtoReg: idEx.MemtoReg, MemWrite: idEx.MemWrite};
         memWb <= '{RegWrite: exMem.RegWrite, MemtoReg: exMem.MemtoReg};
      end
   end

   assign bus.o_RegWriteD   = idCtrl.RegWrite;
   assign bus.o_BranchD     = branchD;
   assign bus.o_BranchNeD   = branchNeD;
   assign bus.o_JumpD       = jumpD;
   assign bus.o_IllegalD    = illegalD;
   assign bus.o_ALUControlE = ALUCTRL_W'(idEx.ALUControl);
   assign bus.o_ALUSrcE     = idEx.ALUSrc;
   assign bus.o_RegDstE     = idEx.RegDst;
   assign bus.o_MemWriteM   = exMem.MemWrite;
   assign bus.o_MemtoRegM   = exMem.MemtoReg;
   assign bus.o_RegWriteM   = exMem.RegWrite;
   assign bus.o_MemtoRegW   = memWb.MemtoReg;
   assign bus.o_RegWriteW   = memWb.RegWrite;

`ifdef CU_MDU_EN
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MDU_LAT - 1);

   mdState_t         state;
   mdState_t         stateNext;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cntNext;
   logic             mdStart;
   logic             mdDone;
   logic             idNeedsMdu;

   // A mult or mflo in ID waits until the running product is in its final cycle.
   assign idNeedsMdu = idCtrl.MdStart || idCtrl.Mflo;
   assign stall      = idNeedsMdu && (((state == MD_BUSY) && (cnt != '0)) || idEx.MdStart);
   assign mdStart    = idCtrl.MdStart && !bus.i_FlushE && !stall;

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= MD_IDLE;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         cnt   <= cntNext;
      end
   end

   // Sequencer starts on the edge that registers a real mult into EX; a mult
   // entering on the final cycle reloads the counter so BUSY runs on without a gap.
   always_comb begin
      stateNext = state;
      cntNext   = cnt;
      mdDone    = 1'b0;
      case (state)
         MD_IDLE: begin
            if (mdStart) begin
               stateNext = MD_BUSY;
               cntNext   = CNT_LOAD;
            end
         end
         MD_BUSY: begin
            if (cnt == '0) begin
               mdDone = 1'b1;
               if (mdStart) begin
                  cntNext = CNT_LOAD;
               end else begin
                  stateNext = MD_IDLE;
               end
            end else begin
               cntNext = cnt - 1'b1;
            end
         end
         default: stateNext = MD_IDLE;
      endcase
   end

   assign bus.o_MdBusy  = (state == MD_BUSY);
   assign bus.o_MdDone  = mdDone;
   assign bus.o_StallMd = stall;
   assign bus.o_MfloE   = idEx.Mflo;
`else
   localparam int unusedMduParams = MDU_LAT + CNT_W;

   logic unusedMduBits;

   assign unusedMduBits = idEx.Mflo ^ idEx.MdStart;
   assign stall         = 1'b0;
   assign bus.o_MdBusy  = 1'b0;
   assign bus.o_MdDone  = 1'b0;
   assign bus.o_StallMd = 1'b0;
   assign bus.o_MfloE   = 1'b0;
`endif

endmodule
